// File: rtl/dna_match_engine_if.sv
// dna_match_engine_if: search request and result bus for dna_match_engine
interface dna_match_engine_if;
  logic        start;
  logic [44:0] ref_seq;
  logic [44:0] query_seq;
  logic [44:0] seq1;
  logic [44:0] seq2;
  logic [3:0]  index10;
  logic [3:0]  index1;
  logic        found;
  logic        busy;
  logic        done;
  modport master (
    output start, ref_seq, query_seq,
    input  seq1, seq2, index10, index1, found, busy, done
  );
  modport slave (
    input  start, ref_seq, query_seq,
    output seq1, seq2, index10, index1, found, busy, done
  );
endinterface

// File: rtl/dna_match_engine.sv
// dna_match_engine: sliding query-vs-reference search with BCD 1-based match index.
// Define DNA_MISMATCH_TOL_EN to accept alignments with a single base mismatch.
module dna_match_engine #(
  parameter int QLEN = 5
) (
  input logic CLOCK_100,
  input logic RESET,
  dna_match_engine_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_COMPARE, S_CONVERT, S_DONE} state_t;
  localparam logic [44:0] QMASK = (45'd1 << (3 * QLEN)) - 45'd1;
  localparam logic [3:0] LAST = 4'(15 - QLEN);
  state_t      r_state;
  logic [3:0]  r_pos;
  logic [3:0]  r_tens;
  logic [4:0]  r_bin;
  logic [44:0] r_ref;
  logic [44:0] r_query;
  logic [44:0] r_seq1;
  logic [44:0] r_seq2;
  logic [3:0]  r_idx10;
  logic [3:0]  r_idx1;
  logic        r_found;
  logic        r_busy;
  logic        r_done;
  logic [44:0] w_win;
  logic        w_hit;
  assign w_win = r_ref >> (3 * r_pos);
`ifdef DNA_MISMATCH_TOL_EN
  logic [14:0] w_mm;
  always_comb begin
    w_mm = '0;
    for (int j = 0; j < QLEN; j++) w_mm[j] = w_win[3*j +: 3] != r_query[3*j +: 3];
  end
  // zero or one bit set in the mismatch vector means at most one differing base
  assign w_hit = (w_mm & (w_mm - 15'd1)) == 15'd0;
`else
  assign w_hit = (w_win & QMASK) == r_query;
`endif
  always_ff @(posedge CLOCK_100) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_pos   <= '0;
      r_tens  <= '0;
      r_bin   <= '0;
      r_ref   <= '0;
      r_query <= '0;
      r_seq1  <= '0;
      r_seq2  <= '0;
      r_idx10 <= 4'hF;
      r_idx1  <= 4'hF;
      r_found <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: if (bus.start) begin
          r_ref   <= bus.ref_seq;
          r_query <= bus.query_seq & QMASK;
          r_seq1  <= bus.ref_seq;
          r_pos   <= '0;
          r_tens  <= '0;
          r_busy  <= 1'b1;
          r_state <= S_COMPARE;
        end
        S_COMPARE: if (w_hit) begin
          r_bin   <= 5'(r_pos) + 5'd1;
          r_tens  <= '0;
          r_state <= S_CONVERT;
        end else if (r_pos == LAST) begin
          r_found <= 1'b0;
          r_idx10 <= 4'hF;
          r_idx1  <= 4'hF;
          r_seq2  <= r_query;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end else begin
          r_pos <= r_pos + 4'd1;
        end
        S_CONVERT: if (r_bin >= 5'd10) begin
          r_bin  <= r_bin - 5'd10;
          r_tens <= r_tens + 4'd1;
        end else begin
          r_idx10 <= r_tens;
          r_idx1  <= r_bin[3:0];
          r_found <= 1'b1;
          r_seq2  <= r_query << (3 * r_pos);
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign bus.seq1    = r_seq1;
  assign bus.seq2    = r_seq2;
  assign bus.index10 = r_idx10;
  assign bus.index1  = r_idx1;
  assign bus.found   = r_found;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
endmodule

// File: tb/tb_dna_match_engine.sv
// tb_dna_match_engine: directed and randomized search checks against a base-level reference model
module tb_dna_match_engine;
  localparam int Q = 5;
`ifdef DNA_MISMATCH_TOL_EN
  localparam int TOL = 1;
`else
  localparam int TOL = 0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  dna_match_engine_if bus();
  dna_match_engine #(.QLEN(Q)) dut (.CLOCK_100(clk), .RESET(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [44:0] got, input logic [44:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [44:0] enc(input string s);
    logic [44:0] v = '0;
    for (int i = 0; i < s.len(); i++)
      v[3*i +: 3] = s[i] == "A" ? 3'd1 : s[i] == "C" ? 3'd2 : s[i] == "G" ? 3'd3 : s[i] == "T" ? 3'd4 : 3'd0;
    return v;
  endfunction
  task automatic model(input logic [44:0] r, input logic [44:0] q, output logic f,
                       output logic [3:0] t, output logic [3:0] u, output logic [44:0] s2, output int lat);
    int hp = -1;
    for (int p = 0; p <= 15 - Q; p++) begin
      int mm = 0;
      for (int j = 0; j < Q; j++) if (r[3*(p+j) +: 3] != q[3*j +: 3]) mm++;
      if (mm <= TOL && hp < 0) hp = p;
    end
    s2 = '0;
    for (int j = 0; j < Q; j++) s2[3*((hp < 0 ? 0 : hp) + j) +: 3] = q[3*j +: 3];
    f   = hp >= 0;
    t   = hp >= 0 ? 4'((hp + 1) / 10) : 4'hF;
    u   = hp >= 0 ? 4'((hp + 1) % 10) : 4'hF;
    lat = hp >= 0 ? hp + 2 + (hp + 1) / 10 : 16 - Q;
  endtask
  task automatic search(input string tag, input logic [44:0] r, input logic [44:0] q);
    logic f;
    logic [3:0] t, u;
    logic [44:0] s2;
    int lat, k;
    model(r, q, f, t, u, s2, lat);
    bus.start = 1'b1;
    bus.ref_seq = r;
    bus.query_seq = q;
    @(posedge clk);
    #1 bus.start = 1'b0;
    chk({tag, ".busy"}, 45'(bus.busy), 45'd1);
    chk({tag, ".seq1"}, bus.seq1, r);
    k = 0;
    while (!bus.done && k < 40) begin
      @(posedge clk);
      k++;
      #1;
    end
    chk({tag, ".lat"}, 45'(k), 45'(lat));
    chk({tag, ".found"}, 45'(bus.found), 45'(f));
    chk({tag, ".idx"}, 45'({bus.index10, bus.index1}), 45'({t, u}));
    chk({tag, ".seq2"}, bus.seq2, s2);
    @(posedge clk);
    #1;
    chk({tag, ".pulse"}, 45'({bus.done, bus.busy}), 45'd0);
    chk({tag, ".hold"}, 45'({bus.found, bus.index10, bus.index1}), 45'({f, t, u}));
  endtask
  initial begin
    logic [44:0] r, q;
    int n, first;
    logic [8:0] snap;
    bus.start = 1'b0;
    bus.ref_seq = '0;
    bus.query_seq = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.out", 45'({bus.found, bus.busy, bus.done, bus.index10, bus.index1}), 45'h0FF);
    chk("rst.seq", bus.seq1 | bus.seq2, 45'd0);
    bus.start = 1'b1;
    @(posedge clk);
    #1 chk("rst.prio", 45'(bus.busy), 45'd0);
    bus.start = 1'b0;
    rst = 1'b0;
    r = enc("ACGTACGTTGCAAAC");
    search("mid", r, enc("GTTGC"));
    chk("mid.idx07", 45'({bus.index10, bus.index1}), 45'h07);
    search("last", r, enc("CAAAC"));
    chk("last.idx11", 45'({bus.index10, bus.index1}), 45'h11);
    search("miss", r, enc("TTTTT"));
    chk("miss.seq2", bus.seq2, enc("TTTTT"));
    search("tol", r, enc("GTAGC"));
    chk("tol.idx", 45'({bus.index10, bus.index1}), TOL ? 45'h07 : 45'hFF);
    search("qhi", r, enc("GTTGCTTTTT"));
    bus.start = 1'b1;
    bus.query_seq = enc("GTTGC");
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1 bus.start = 1'b1;
    bus.query_seq = enc("CAAAC");
    @(posedge clk);
    #1 bus.start = 1'b0;
    n = 0;
    first = -1;
    snap = '0;
    for (int e = 4; e <= 24; e++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        n++;
        if (first < 0) begin
          first = e;
          snap = {bus.found, bus.index10, bus.index1};
        end
      end
    end
    chk("bsy.pulses", 45'(n), 45'd1);
    chk("bsy.edge", 45'(first), 45'd8);
    chk("bsy.res", 45'(snap), 45'h107);
    chk("bsy.seq2", bus.seq2, enc("      GTTGC"));
    bus.start = 1'b1;
    bus.query_seq = enc("GTTGC");
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("mrst.out", 45'({bus.found, bus.busy, bus.done, bus.index10, bus.index1}), 45'h0FF);
    chk("mrst.seq", bus.seq1 | bus.seq2, 45'd0);
    n = 0;
    repeat (15) begin
      @(posedge clk);
      #1 if (bus.done) n++;
    end
    chk("mrst.nodone", 45'(n), 45'd0);
    search("after", r, enc("GTTGC"));
    for (int i = 0; i < 24; i++) begin
      int p;
      r = '0;
      for (int b = 0; b < 15; b++) r[3*b +: 3] = 3'($urandom_range(1, 4));
      p = $urandom_range(0, 15 - Q);
      q = '0;
      for (int j = 0; j < Q; j++)
        q[3*j +: 3] = i % 3 == 2 ? 3'($urandom_range(1, 4)) : r[3*(p+j) +: 3];
      if (i % 3 == 1) q[3*$urandom_range(0, Q - 1) +: 3] = 3'($urandom_range(1, 4));
      search($sformatf("rnd%0d", i), r, q);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dna_match_engine.md
DNA_MATCH_ENGINE -- requirements
Module: dna_match_engine

Interface
REQ-001 SHALL have parameter QLEN, default 5: query length in bases, legal range 1..15.
REQ-002 SHALL have port CLOCK_100  in  1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RESET  in  1: reset; synchronous, active-high.
REQ-004 SHALL have port start  in  1: request one search; sampled only in IDLE.
REQ-005 SHALL have port ref_seq  in  45: 15 bases; base i at bits [3i+2:3i]; codes blank=000, A=001, C=010, G=011, T=100.
REQ-006 SHALL have port query_seq  in  45: query bases 0..QLEN-1 in the low 3*QLEN bits; upper bits ignored.
REQ-007 SHALL have port seq1  out  45: latched reference, for display.
REQ-008 SHALL have port seq2  out  45: query aligned to the match position; blank elsewhere.
REQ-009 SHALL have port index10  out  4: BCD tens digit of the 1-based match position.
REQ-010 SHALL have port index1  out  4: BCD units digit of the 1-based match position.
REQ-011 SHALL have port found  out  1: last search hit.
REQ-012 SHALL have port busy  out  1: high in every state except IDLE.
REQ-013 SHALL have port done  out  1: one-cycle pulse at search end.

Function
REQ-014 SHALL implement the FSM states IDLE, COMPARE, CONVERT and DONE.
REQ-015 SHALL, in IDLE with start=1, latch ref_seq and query_seq, set pos=0 and go to COMPARE; this edge is edge 0.
REQ-016 SHALL, in COMPARE, evaluate one alignment pos per cycle; the mismatch count is the number of j in 0..QLEN-1 with query base j != ref base pos+j.
REQ-017 SHALL treat an alignment as a hit when its mismatch count <= TOL (see REQ-027).
REQ-018 SHALL, on a hit, go to CONVERT with bin=pos+1 (5-bit); the first, lowest pos wins.
REQ-019 SHALL, on a miss with pos<15-QLEN, increment pos and stay in COMPARE.
REQ-020 SHALL, on a miss at pos=15-QLEN, go to DONE with found=0, index10=index1=4'hF and seq2=query at position 0.
REQ-021 SHALL, in CONVERT, perform one step per cycle: if bin>=10, subtract 10 and increment tens; otherwise write index10=tens, index1=bin, found=1, seq2=query shifted by 3*pos bits, and go to DONE.
REQ-022 SHALL assert done for exactly one cycle in DONE, then return to IDLE.
REQ-023 SHALL set done latency as follows, counted in edges after edge 0: hit at pos with c tens subtractions gives done high after edge pos+c+2; no hit gives done high after edge 16-QLEN.
REQ-024 SHALL ignore start while busy=1, with no queuing and no restart.
REQ-025 SHALL hold seq1, seq2, index10, index1 and found stable from DONE until the next accepted start; seq1 SHALL update at edge 0.

Reset
REQ-026 SHALL, with RESET high at any edge including mid-search: go to IDLE; pos, tens and bin = 0; seq1 = seq2 = 0; index10 = index1 = 4'hF; found = busy = done = 0. RESET SHALL take priority over start.

Configuration
REQ-027 SHALL provide macro DNA_MISMATCH_TOL_EN: when defined, TOL=1 and an alignment with one base mismatch is a hit; when undefined, TOL=0, exact match only, and the mismatch-count logic reduces to an equality compare.

Verification
REQ-028 SHALL cover the exact mid hit: ref=ACGTACGTTGCAAAC (base 0 first), query=GTTGC, start -> pos=6, found=1, index10=0, index1=7, seq2 holds GTTGC at bases 6..10, done high after edge 8.
REQ-029 SHALL cover the last-position hit: same ref, query=CAAAC -> pos=10, index10=1, index1=1, done high after edge 13 (one subtraction).
REQ-030 SHALL cover the no hit: same ref, query=TTTTT -> found=0, index10=index1=F, seq2=TTTTT at bases 0..4, done high after edge 11.
REQ-031 SHALL cover the tolerance: same ref, query=GTAGC -> with DNA_MISMATCH_TOL_EN, found=1, index 07; without it, found=0, index FF.
REQ-032 SHALL cover start while busy: second start 3 cycles after the first -> ignored, single done pulse, results from the first request only.
REQ-033 SHALL cover reset mid-COMPARE: RESET high at edge 4 -> next cycle busy=0, all outputs at reset values, no done pulse; a new start then completes normally.
